axis_pkt_gen: RTL and testbench

AXI4-Stream packet transmitter. Drives the master side of an axistream_if, producing framed packets with a deterministic incrementing data pattern. Serves as the traffic source for stream datapaths and their benches. Honours tready backpressure with full payload stability and applies a configurable inter-packet gap.

---
 rtl/axis_pkt_gen_pkg.sv | 27 ++
 rtl/axistream_if.sv | 22 ++
 rtl/axis_pkt_gen.sv | 158 +++++++++++++++
 tb/tb_axis_pkt_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_gen_pkg.sv
// Shared types for the AXI4-Stream packet generator.
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  // Config fields are held at their widest supported size; the generator
  // zero-extends its narrower ports into them and reads back only the low bits.
  localparam int CFG_LEN_W  = 32;
  localparam int CFG_PKTS_W = 16;
  localparam int CFG_GAP_W  = 32;
  localparam int CFG_SEED_W = 64;
  localparam int CFG_ID_W   = 16;
  localparam int CFG_DEST_W = 16;
  localparam int KEEP_W     = CFG_SEED_W / 8;

  typedef struct packed {
    logic [CFG_LEN_W-1:0]  len;
    logic [CFG_PKTS_W-1:0] pkts;
    logic [CFG_GAP_W-1:0]  gap;
    logic [CFG_SEED_W-1:0] seed;
    logic [CFG_ID_W-1:0]   id;
    logic [CFG_DEST_W-1:0] dest;
  } cfg_t;

  localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

endpackage

// File: rtl/axistream_if.sv
// AXI4-Stream bundle with master/slave views.
interface axistream_if #(
  parameter int DWIDTH     = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 4
);
  logic                    tvalid;
  logic                    tready;
  logic [DWIDTH-1:0]       tdata;
  logic [DWIDTH/8-1:0]     tkeep;
  logic [DWIDTH/8-1:0]     tstrb;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                  input  tready);
  modport slave  (input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                  output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet source: framed packets of an incrementing data pattern,
// tready backpressure, configurable inter-packet gap, graceful stop.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 4,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [15:0]           cfg_pkts,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [DWIDTH-1:0]     cfg_seed,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  axistream_if.master           m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pkts_sent,
  output logic [31:0]           beats_sent
);

  state_e                 state;
  cfg_t                   cfg_q;
  logic                   stop_pending;
  logic [LEN_WIDTH-1:0]   beat_idx;
  logic [GAP_WIDTH-1:0]   gap_cnt;

  logic                   tvalid_q, tlast_q;
  logic [DWIDTH-1:0]      tdata_q;
  logic [USER_WIDTH-1:0]  tuser_q;
  logic [ID_WIDTH-1:0]    tid_q;
  logic [DEST_WIDTH-1:0]  tdest_q;

  logic [LEN_WIDTH-1:0]   len_c;
  logic [GAP_WIDTH-1:0]   gap_c;
  logic [15:0]            pkts_c, pkts_inc;
  logic                   xfer, run_end;
  logic                   unused_cfg;

  assign len_c  = cfg_q.len[LEN_WIDTH-1:0];
  assign gap_c  = cfg_q.gap[GAP_WIDTH-1:0];
  assign pkts_c = cfg_q.pkts;
  // Upper bits of the wide config fields are always zero and never read.
  assign unused_cfg = ^cfg_q;

  assign xfer     = tvalid_q & m_axis.tready;
  assign pkts_inc = pkts_sent + 16'd1;
  // Evaluated only on a last-beat transfer: does this packet close the run?
  assign run_end  = stop_pending | stop | ((pkts_c != 16'd0) && (pkts_inc == pkts_c));

  // Run FSM, counters and the registered output stage.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      cfg_q        <= '0;
      stop_pending <= 1'b0;
      beat_idx     <= '0;
      gap_cnt      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= '0;
      tid_q        <= '0;
      tdest_q      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pkts_sent    <= '0;
      beats_sent   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && cfg_len != '0) begin
            cfg_q.len    <= CFG_LEN_W'(cfg_len);
            cfg_q.pkts   <= cfg_pkts;
            cfg_q.gap    <= CFG_GAP_W'(cfg_gap);
            cfg_q.seed   <= CFG_SEED_W'(cfg_seed);
            cfg_q.id     <= CFG_ID_W'(cfg_id);
            cfg_q.dest   <= CFG_DEST_W'(cfg_dest);
            state        <= SEND;
            stop_pending <= 1'b0;
            beat_idx     <= '0;
            tvalid_q     <= 1'b1;
            tlast_q      <= (cfg_len == LEN_WIDTH'(1));
            tdata_q      <= cfg_seed;
            tuser_q      <= '0;
            tid_q        <= cfg_id;
            tdest_q      <= cfg_dest;
            busy         <= 1'b1;
            pkts_sent    <= '0;
            beats_sent   <= '0;
          end
        end
        SEND: begin
          if (stop) stop_pending <= 1'b1;
          if (xfer) begin
            if (beats_sent != '1) beats_sent <= beats_sent + 32'd1;
            tdata_q <= tdata_q + DWIDTH'(1);
            if (tlast_q) begin
              pkts_sent <= pkts_inc;
              beat_idx  <= '0;
              tuser_q   <= USER_WIDTH'(pkts_inc);
              if (run_end) begin
                state    <= IDLE;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                done     <= 1'b1;
                busy     <= 1'b0;
              end else if (gap_c == '0) begin
                tlast_q <= (len_c == LEN_WIDTH'(1));
              end else begin
                state    <= GAP;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                gap_cnt  <= gap_c - GAP_WIDTH'(1);
              end
            end else begin
              beat_idx <= beat_idx + LEN_WIDTH'(1);
              tlast_q  <= (beat_idx + LEN_WIDTH'(1) == len_c - LEN_WIDTH'(1));
            end
          end
        end
        GAP: begin
          if (stop || stop_pending) begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (gap_cnt == '0) begin
            state    <= SEND;
            tvalid_q <= 1'b1;
            tlast_q  <= (len_c == LEN_WIDTH'(1));
          end else begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tid    = tid_q;
  assign m_axis.tdest  = tdest_q;
  assign m_axis.tkeep  = KEEP_ALL[DWIDTH/8-1:0];
  assign m_axis.tstrb  = KEEP_ALL[DWIDTH/8-1:0];

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: 32-bit main instance plus an 8-bit one for wrap.
module tb_axis_pkt_gen;

  logic        aclk = 1'b0;
  logic        areset, start, start8, stop, tready;
  logic [15:0] cfg_len, cfg_pkts;
  logic [7:0]  cfg_gap;
  logic [31:0] cfg_seed;
  logic [7:0]  cfg_seed8;
  logic [3:0]  cfg_id;
  logic [0:0]  cfg_dest;
  logic        busy, done, busy8, done8;
  logic [15:0] pkts_sent, pkts8;
  logic [31:0] beats_sent, beats8;

  int n_chk = 0;
  int n_err = 0;

  axistream_if #(.DWIDTH(32)) axis  ();
  axistream_if #(.DWIDTH(8))  axis8 ();
  assign axis.tready  = tready;
  assign axis8.tready = 1'b1;

  axis_pkt_gen #(.DWIDTH(32)) dut (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_pkts(cfg_pkts), .cfg_gap(cfg_gap),
    .cfg_seed(cfg_seed), .cfg_id(cfg_id), .cfg_dest(cfg_dest),
    .m_axis(axis), .busy(busy), .done(done),
    .pkts_sent(pkts_sent), .beats_sent(beats_sent)
  );

  axis_pkt_gen #(.DWIDTH(8)) dut8 (
    .aclk(aclk), .areset(areset), .start(start8), .stop(stop),
    .cfg_len(cfg_len), .cfg_pkts(cfg_pkts), .cfg_gap(cfg_gap),
    .cfg_seed(cfg_seed8), .cfg_id(cfg_id), .cfg_dest(cfg_dest),
    .m_axis(axis8), .busy(busy8), .done(done8),
    .pkts_sent(pkts8), .beats_sent(beats8)
  );

  // 100 MHz clock
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] d, input logic l, input logic [3:0] u);
    check({tag, ".tvalid"}, 64'(axis.tvalid), 64'd1);
    check({tag, ".tdata"},  64'(axis.tdata),  64'(d));
    check({tag, ".tlast"},  64'(axis.tlast),  64'(l));
    check({tag, ".tuser"},  64'(axis.tuser),  64'(u));
  endtask

  task automatic go(input logic [15:0] len, input logic [15:0] pkts,
                    input logic [7:0] gap, input logic [31:0] seed);
    cfg_len = len; cfg_pkts = pkts; cfg_gap = gap; cfg_seed = seed;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; start8 = 1'b0; stop = 1'b0; tready = 1'b1;
    cfg_len = 16'd4; cfg_pkts = 16'd2; cfg_gap = 8'd0; cfg_seed = 32'h10;
    cfg_seed8 = 8'hFE; cfg_id = 4'd5; cfg_dest = 1'b1;
    tick(); tick();

    // reset state
    check("rst.tvalid", 64'(axis.tvalid), 64'd0);
    check("rst.tlast",  64'(axis.tlast),  64'd0);
    check("rst.tdata",  64'(axis.tdata),  64'd0);
    check("rst.tkeep",  64'(axis.tkeep),  64'hF);
    check("rst.tstrb",  64'(axis.tstrb),  64'hF);
    check("rst.busy",   64'(busy),        64'd0);
    check("rst.done",   64'(done),        64'd0);
    check("rst.cnt",    64'({pkts_sent, beats_sent}), 64'd0);
    areset = 1'b0;
    tick();

    // 1: basic back-to-back run
    go(16'd4, 16'd2, 8'd0, 32'h10);
    check("t1.busy", 64'(busy), 64'd1);
    check("t1.tid",  64'(axis.tid), 64'd5);
    check("t1.tdest", 64'(axis.tdest), 64'd1);
    for (int i = 0; i < 8; i++) begin
      beat("t1", 32'h10 + 32'(i), (i % 4) == 3, 4'(i / 4));
      check("t1.done_early", 64'(done), 64'd0);
      tick();
    end
    check("t1.done",   64'(done),  64'd1);
    check("t1.tvalid", 64'(axis.tvalid), 64'd0);
    check("t1.busy0",  64'(busy),  64'd0);
    check("t1.pkts",   64'(pkts_sent),  64'd2);
    check("t1.beats",  64'(beats_sent), 64'd8);
    tick();
    check("t1.done_pulse", 64'(done), 64'd0);
    check("t1.hold", 64'({pkts_sent, beats_sent}), {32'd0, 16'd2, 32'd8} & 64'hFFFF_FFFF_FFFF);

    // 2: backpressure, tready 1,0,0,1,0,1
    begin
      logic [5:0] pat;
      int k;
      pat = 6'b101001;  // bit i = tready on cycle i
      k = 0;
      go(16'd3, 16'd1, 8'd0, 32'h100);
      for (int i = 0; i < 6; i++) begin
        tready = pat[i];
        beat("t2", 32'h100 + 32'(k), k == 2, 4'd0);
        tick();
        if (pat[i]) k++;
      end
      tready = 1'b1;
      check("t2.done",  64'(done), 64'd1);
      check("t2.beats", 64'(beats_sent), 64'd3);
      check("t2.pkts",  64'(pkts_sent), 64'd1);
    end
    tick();

    // 3: five-cycle gap between packets, none after the last
    go(16'd2, 16'd3, 8'd5, 32'h0);
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 2; b++) begin
        beat("t3", 32'(2 * p + b), b == 1, 4'(p));
        tick();
      end
      if (p < 2) begin
        for (int g = 0; g < 5; g++) begin
          check("t3.gap_tvalid", 64'(axis.tvalid), 64'd0);
          check("t3.gap_busy",   64'(busy), 64'd1);
          tick();
        end
      end
    end
    check("t3.done", 64'(done), 64'd1);
    check("t3.beats", 64'(beats_sent), 64'd6);
    tick();

    // 4: continuous run, stop on beat 2 of packet 3 -> packet completes
    go(16'd4, 16'd0, 8'd0, 32'h20);
    for (int i = 0; i < 12; i++) begin
      stop = (i == 9);
      beat("t4", 32'h20 + 32'(i), (i % 4) == 3, 4'(i / 4));
      tick();
    end
    stop = 1'b0;
    check("t4.done", 64'(done), 64'd1);
    check("t4.pkts", 64'(pkts_sent), 64'd3);
    check("t4.beats", 64'(beats_sent), 64'd12);
    tick();
    stop = 1'b1;  // ignored in IDLE
    tick();
    stop = 1'b0;
    check("t4.idle_stop", 64'({busy, done}), 64'd0);

    // 4b: start+stop together (start wins), start while busy ignored,
    // stop coinciding with a last-beat transfer ends the run there
    stop = 1'b1;
    go(16'd2, 16'd0, 8'd0, 32'h80);
    stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start = (i == 1);
      cfg_seed = (i == 1) ? 32'h999 : 32'h80;
      stop  = (i == 7);
      beat("t4b", 32'h80 + 32'(i), (i % 2) == 1, 4'(i / 2));
      tick();
    end
    start = 1'b0; stop = 1'b0;
    check("t4b.done", 64'(done), 64'd1);
    check("t4b.pkts", 64'(pkts_sent), 64'd4);
    check("t4b.beats", 64'(beats_sent), 64'd8);
    tick();

    // 5: 8-bit wrap with single-beat packets
    cfg_len = 16'd1; cfg_pkts = 16'd3; cfg_gap = 8'd0; cfg_seed8 = 8'hFE;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e8;
      e8 = cfg_seed8 + 8'(i);
      check("t5.tvalid", 64'(axis8.tvalid), 64'd1);
      check("t5.tdata",  64'(axis8.tdata),  64'(e8));
      check("t5.tlast",  64'(axis8.tlast),  64'd1);
      tick();
    end
    check("t5.done", 64'(done8), 64'd1);
    check("t5.busy", 64'(busy8), 64'd0);
    check("t5.pkts", 64'(pkts8), 64'd3);
    check("t5.beats", 64'(beats8), 64'd3);
    // cfg_len = 0 start is ignored
    go(16'd0, 16'd1, 8'd0, 32'h55);
    for (int i = 0; i < 3; i++) begin
      check("t5.len0", 64'({axis.tvalid, busy, done}), 64'd0);
      tick();
    end

    // 6: reset mid-packet, then a fresh run
    go(16'd5, 16'd1, 8'd0, 32'h40);
    tick(); tick();
    beat("t6.pre", 32'h42, 1'b0, 4'd0);
    tready = 1'b0; areset = 1'b1;
    tick();
    areset = 1'b0; tready = 1'b1;
    check("t6.tvalid", 64'(axis.tvalid), 64'd0);
    check("t6.busy",   64'(busy), 64'd0);
    check("t6.cnt",    64'({pkts_sent, beats_sent}), 64'd0);
    go(16'd2, 16'd1, 8'd0, 32'h40);
    beat("t6.b0", 32'h40, 1'b0, 4'd0);
    tick();
    beat("t6.b1", 32'h41, 1'b1, 4'd0);
    tick();
    check("t6.done", 64'(done), 64'd1);
    check("t6.beats", 64'(beats_sent), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
